// File: rtl/decoder_3_8_pulse_pkg.sv
// Shared definitions for the pulsed 3-to-8 decoder: FSM encoding, FIFO depth
// and the index-to-one-hot helper used by the decode path.
package decoder_3_8_pulse_pkg;

  // FSM state encoding, kept as plain constants for legacy tools
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Input buffer depth and datapath widths
  localparam int FIFO_DEPTH = 2;
  localparam int IDX_W      = 3;
  localparam int CNT_W      = 4;
  localparam int OUT_W      = 8;

  // Index 0 is a real index and decodes to bit 0; validity comes from z
  function automatic logic [OUT_W-1:0] onehot8(input logic [IDX_W-1:0] idx);
    onehot8 = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/decoder_3_8_pulse_pe_fifo2.sv
// Two-entry in-order FIFO holding encoded indices between the priority
// encoder and the pulse FSM. Push when full and pop when empty are ignored.
module pe_fifo2
  import decoder_3_8_pulse_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [IDX_W-1:0] data_i,
  output logic [IDX_W-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [IDX_W-1:0] mem0_q, mem0_d;
  logic [IDX_W-1:0] mem1_q, mem1_d;
  logic             wrPtr_q, wrPtr_d;
  logic             rdPtr_q, rdPtr_d;
  logic [1:0]       count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign doPush  = push_i && (count_q != DEPTH);
  assign doPop   = pop_i && (count_q != 2'd0);
  assign data_o  = rdPtr_q ? mem1_q : mem0_q;
  assign full_o  = (count_q == DEPTH);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

  // Next-state for storage, pointers and occupancy; push and pop may coincide
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      if (wrPtr_q) begin
        mem1_d = data_i;
      end else begin
        mem0_d = data_i;
      end
      wrPtr_d = ~wrPtr_q;
    end
    if (doPop) begin
      rdPtr_d = ~rdPtr_q;
    end
    count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
  end

  // Register FIFO state; reset empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/decoder_3_8_pulse.sv
// Pulsed 3-to-8 decoder: buffers indices in a 2-entry FIFO and drives each
// as a registered one-hot word for HOLD cycles, separated by GAP idle cycles.
module decoder_3_8_pulse
  import decoder_3_8_pulse_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] y,
  input  logic             z,
  output logic             ready,
  output logic [OUT_W-1:0] d,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
  localparam bit               GAP_EN    = (GAP > 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] d_q, d_d;
  logic             alive_q;

  logic             fifoPush;
  logic             fifoPop;
  logic [IDX_W-1:0] fifoHead;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [1:0]       fifoCount;

  // alive_q keeps ready low until the first edge after reset release, so
  // ready depends only on registered state and never on the pop decision
  assign ready    = alive_q && !fifoFull;
  assign fifoPush = z && ready;
  assign d        = d_q;
  assign done     = (state_q == ST_HOLD) && (cnt_q == '0);
  assign busy     = (state_q != ST_IDLE) || (fifoCount != 2'd0);

  pe_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .data_i  (y),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // FSM: pop an index, hold its one-hot word, then insert the idle gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    fifoPop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        d_d = '0;
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          d_d     = onehot8(fifoHead);
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_EN) begin
          d_d     = '0;
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else if (!fifoEmpty) begin
          fifoPop = 1'b1;
          d_d     = onehot8(fifoHead);
          cnt_d   = HOLD_LOAD;
        end else begin
          d_d     = '0;
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        d_d = '0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!fifoEmpty) begin
          fifoPop = 1'b1;
          d_d     = onehot8(fifoHead);
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        d_d     = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register FSM, counter and output word; reset discards any active entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      alive_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_3_8_pulse.sv
// Directed bench for decoder_3_8_pulse: one instance with HOLD=4/GAP=1 and
// one with HOLD=1/GAP=0, checked against hand-computed cycle tables.
module tb_decoder_3_8_pulse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] y, y2;
  logic       z, z2;
  logic       ready, ready2;
  logic [7:0] d, d2;
  logic       busy, busy2;
  logic       done, done2;

  int vectors     = 0;
  int miscompares = 0;
  bit monEn       = 1'b0;

  always #5 clk = ~clk;

  decoder_3_8_pulse #(.HOLD(4), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .y(y), .z(z),
    .ready(ready), .d(d), .busy(busy), .done(done)
  );

  decoder_3_8_pulse #(.HOLD(1), .GAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .y(y2), .z(z2),
    .ready(ready2), .d(d2), .busy(busy2), .done(done2)
  );

  // Every-cycle invariant: at most one bit of d set, d and done only while busy
  always @(negedge clk) begin
    if (monEn && rst_n === 1'b1) begin
      vectors++;
      if ($countones(d) > 1 || (d != 8'h00 && busy !== 1'b1) || (done === 1'b1 && d == 8'h00)) begin
        miscompares++;
        $display("[TB] FAIL inv_dut1 d=%h busy=%b done=%b required one-hot-or-zero, busy when d!=0", d, busy, done);
      end
      vectors++;
      if ($countones(d2) > 1 || (d2 != 8'h00 && busy2 !== 1'b1) || (done2 === 1'b1 && d2 == 8'h00)) begin
        miscompares++;
        $display("[TB] FAIL inv_dut2 d=%h busy=%b done=%b required one-hot-or-zero, busy when d!=0", d2, busy2, done2);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int idxOf(input logic [7:0] v);
    int r;
    r = -1;
    if ($countones(v) == 1) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) r = i;
      end
    end
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b1;
    y = 3'd0; z = 1'b0; y2 = 3'd0; z2 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({d, done, busy, ready} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_assert got d=%h done=%b busy=%b ready=%b want 00/0/0/0", d, done, busy, ready);
    end
    tick;
    tick;
    vectors++;
    if ({d, done, busy, ready, d2, ready2} !== {8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_held got d=%h done=%b busy=%b ready=%b d2=%h ready2=%b want all 0",
               d, done, busy, ready, d2, ready2);
    end
    #2 rst_n = 1'b1;
    tick;
    vectors++;
    if ({d, done, busy, ready, ready2, busy2} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_release got d=%h done=%b busy=%b ready=%b ready2=%b busy2=%b want 00/0/0/1/1/0",
               d, done, busy, ready, ready2, busy2);
    end
    monEn = 1'b1;
  endtask

  task automatic test_single;
    logic [7:0] expD;
    logic       expDone, expBusy;
    y = 3'd3; z = 1'b1;
    tick;
    z = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      expD    = (c >= 2 && c <= 5) ? 8'h08 : 8'h00;
      expDone = (c == 5);
      expBusy = (c <= 6);
      vectors++;
      if ({d, done, busy, ready} !== {expD, expDone, expBusy, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL single cyc%0d got d=%h done=%b busy=%b ready=%b want d=%h done=%b busy=%b ready=1",
                 c, d, done, busy, ready, expD, expDone, expBusy);
      end
      if (c < 7) tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] expD;
    logic       expDone, expBusy;
    int         doneCnt;
    doneCnt = 0;
    y = 3'd7; z = 1'b1;
    tick;
    y = 3'd0;
    tick;
    z = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      expD    = (c >= 2 && c <= 5) ? 8'h80 : ((c >= 7 && c <= 10) ? 8'h01 : 8'h00);
      expDone = (c == 5) || (c == 10);
      expBusy = (c <= 11);
      if (done === 1'b1) doneCnt++;
      vectors++;
      if ({d, done, busy} !== {expD, expDone, expBusy}) begin
        miscompares++;
        $display("[TB] FAIL b2b cyc%0d got d=%h done=%b busy=%b want d=%h done=%b busy=%b",
                 c, d, done, busy, expD, expDone, expBusy);
      end
      if (c < 12) tick;
    end
    vectors++;
    if (doneCnt != 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_count got %0d want 2", doneCnt);
    end
  endtask

  task automatic test_backpressure;
    logic [2:0] src [4];
    int         outs [4];
    int         sent, got, extra;
    bit         sawLow, acc;
    src = '{3'd5, 3'd6, 3'd2, 3'd1};
    sent = 0; got = 0; extra = 0; sawLow = 1'b0;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      if (sent < 4) begin
        y = src[sent];
        z = 1'b1;
      end else begin
        z = 1'b0;
      end
      acc = (sent < 4) && (ready === 1'b1);
      tick;
      if (acc) sent++;
      if (ready === 1'b0) sawLow = 1'b1;
      if (done === 1'b1) begin
        if (got < 4) outs[got] = idxOf(d);
        got++;
      end
    end
    z = 1'b0;
    for (int k = 0; k < 20 && busy === 1'b1; k++) begin
      tick;
      if (done === 1'b1) extra++;
    end
    vectors++;
    if (sent != 4 || got != 4) begin
      miscompares++;
      $display("[TB] FAIL bp_counts got sent=%0d outputs=%0d want 4/4", sent, got);
    end
    vectors++;
    if (sawLow != 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_ready_low got sawLow=%b want 1", sawLow);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got > i && outs[i] != int'(src[i])) begin
        miscompares++;
        $display("[TB] FAIL bp_order[%0d] got idx %0d want %0d", i, outs[i], src[i]);
      end
    end
    vectors++;
    if (extra != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_drain got extra=%0d busy=%b want 0/0", extra, busy);
    end
  endtask

  task automatic test_gap0;
    y2 = 3'd2; z2 = 1'b1;
    tick;
    y2 = 3'd4;
    tick;
    z2 = 1'b0;
    vectors++;
    if ({d2, done2, busy2} !== {8'h04, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL gap0_cyc2 got d=%h done=%b busy=%b want 04/1/1", d2, done2, busy2);
    end
    tick;
    vectors++;
    if ({d2, done2, busy2} !== {8'h10, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL gap0_cyc3 got d=%h done=%b busy=%b want 10/1/1", d2, done2, busy2);
    end
    tick;
    vectors++;
    if ({d2, done2, busy2} !== {8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL gap0_cyc4 got d=%h done=%b busy=%b want 00/0/0", d2, done2, busy2);
    end
  endtask

  task automatic test_reset_mid_hold;
    int doneSeen;
    doneSeen = 0;
    y = 3'd6; z = 1'b1;
    tick;
    z = 1'b0;
    tick;
    tick;
    vectors++;
    if ({d, done} !== {8'h40, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rst_hold_pre got d=%h done=%b want 40/0", d, done);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({d, done, busy, ready} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rst_hold_async got d=%h done=%b busy=%b ready=%b want 00/0/0/0", d, done, busy, ready);
    end
    tick;
    if (done === 1'b1) doneSeen++;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (done === 1'b1) doneSeen++;
      vectors++;
      if ({d, busy, ready} !== {8'h00, 1'b0, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL rst_hold_after%0d got d=%h busy=%b ready=%b want 00/0/1", k, d, busy, ready);
      end
    end
    vectors++;
    if (doneSeen != 0) begin
      miscompares++;
      $display("[TB] FAIL rst_hold_done got %0d pulses want 0", doneSeen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gap0();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_3_8_pulse.md
DECODER_3_8_PULSE -- requirements
Module: decoder_3_8_pulse

Interface
REQ-001 SHALL have parameter HOLD, default 4, cycles each one-hot output stays asserted (legal 1..15).
REQ-002 SHALL have parameter GAP, default 1, idle cycles forced between consecutive one-hot outputs (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port y  input  3  encoded index (0..7) from a priority encoder.
REQ-006 SHALL have port z  input  1  index valid; y is accepted when z && ready.
REQ-007 SHALL have port ready  output  1  input FIFO can accept an index this cycle.
REQ-008 SHALL have port d  output  8  registered one-hot decode, d[y] for the active entry, else 0.
REQ-009 SHALL have port busy  output  1  FSM not in IDLE, or FIFO non-empty.
REQ-010 SHALL have port done  output  1  one-cycle pulse in the final HOLD cycle of each output.

Function
REQ-011 SHALL buffer accepted indices in a 2-entry in-order FIFO; ready = (count < 2) from registered count only, never combinationally from pop.
REQ-012 SHALL ignore y whenever z=0 or ready=0; the source holds y/z until accepted; no data lost, no drop counter.
REQ-013 SHALL NOT bypass the FIFO: push into an empty FIFO at edge N, pop at edge N+1 at earliest; d asserted from cycle N+2 (latency 2 cycles, accept to d).
REQ-014 SHALL allow simultaneous push and pop when count is 1; count stays 1, order preserved.
REQ-015 SHALL implement FSM states IDLE, HOLD, GAP.
REQ-016 IDLE: if FIFO non-empty, pop head, load d = 1<<idx, cnt = HOLD-1, go HOLD; else d = 0.
REQ-017 HOLD: d held constant; cnt decrements each cycle; done = 1 when cnt == 0.
REQ-018 HOLD with cnt==0: if GAP>0, d = 0, cnt = GAP-1, go GAP; if GAP==0 and FIFO non-empty, pop and reload d/cnt, stay HOLD (back-to-back); else d = 0, go IDLE.
REQ-019 GAP: d = 0; cnt decrements; at cnt==0, if FIFO non-empty pop and enter HOLD directly, else go IDLE.
REQ-020 SHALL keep d one-hot or zero in every cycle; never more than one bit set.
REQ-021 SHALL size cnt as 4 bits; no wrap since HOLD/GAP limited to 15.
REQ-022 Index 0 SHALL decode to d = 8'b0000_0001 like any other index; z, not y, qualifies validity.

Reset
REQ-023 rst_n low SHALL asynchronously force d = 0, done = 0, busy = 0, ready = 0 while asserted, FSM = IDLE, cnt = 0, FIFO empty.
REQ-024 ready SHALL rise in the first cycle after rst_n deasserts.
REQ-025 Reset mid-HOLD or mid-GAP SHALL discard the active and buffered entries; no done pulse generated for them.

Structure
REQ-026 Shared package/include SHALL hold the FSM state encoding (IDLE=0, HOLD=1, GAP=2, 2-bit) and the FIFO depth constant 2.
REQ-027 FIFO SHALL be a separate sub-module pe_fifo2 (3-bit data, push/pop/full/empty/count); FSM and decode stay in the top.

Verification (HOLD=4, GAP=1 unless stated)
REQ-028 Single: after reset, z=1, y=3 for one cycle at edge 0 -> d=8'h08 during cycles 2-5, done=1 in cycle 5, d=0 in cycle 6, busy=0 from cycle 7.
REQ-029 Back-to-back: push y=7 then y=0 on consecutive edges -> d=8'h80 for 4 cycles, 1 zero cycle, d=8'h01 for 4 cycles; two done pulses.
REQ-030 Backpressure: hold z=1 with y=5,6,2,1 presented in order -> ready drops to 0 when FIFO full, all four outputs appear in order, none lost or duplicated.
REQ-031 GAP=0, HOLD=1: push 2,4 -> d=8'h04 then 8'h10 in adjacent cycles, done high both cycles.
REQ-032 Reset mid-HOLD: push y=6, assert rst_n=0 in cycle 3 -> d=0 immediately (asynchronously), no done, after release busy=0, ready=1, and d stays 0.
REQ-033 Invariant check every cycle: $countones(d) <= 1, and d!=0 only in HOLD.
